// File: rtl/blink_rtc_if.sv
// Register-side bus of the blink real-time clock: acknowledge/mask strobes,
// their shared 3-bit write data, and the status/mask/interrupt readback.
//
// Handshake: tack_wr and tmk_wr are single-cycle write strobes with no
// ready/acknowledge; the slave accepts a strobe on every rising mck edge at
// which it is high, and both strobes may be high in the same cycle.
interface blink_rtc_if;
  logic       tack_wr;
  logic       tmk_wr;
  logic [2:0] wdat;
  logic [2:0] tsta;
  logic [2:0] tmk;
  logic       tirq;

  modport master (
    output tack_wr, tmk_wr, wdat,
    input  tsta, tmk, tirq
  );

  modport slave (
    input  tack_wr, tmk_wr, wdat,
    output tsta, tmk, tirq
  );
endinterface

// File: rtl/blink_rtc.sv
// Blink real-time clock: counts synchronized 5 ms ticks into 5 ms / second /
// minute counters, keeps sticky event flags with a write-1-to-clear
// acknowledge, an interrupt mask and a registered interrupt request.
module blink_rtc (
  input  logic               mck,
  input  logic               rst,
  input  logic               tick,
  input  logic               restim,
  output logic [7:0]         tim0,
  output logic [5:0]         tim1,
  output logic [20:0]        timm,
  blink_rtc_if.slave         bus
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [7:0]  r_tim0;
  logic [5:0]  r_tim1;
  logic [20:0] r_timm;
  logic [2:0]  r_tsta;
  logic [2:0]  r_tmk;
  logic        r_tirq;

  logic        w_tev;
  logic        w_count;
  logic        w_sec;
  logic        w_min;
  logic [2:0]  w_set;
  logic [2:0]  w_clr;

  // Two flops resynchronize the asynchronous tick; the third remembers the
  // previous synchronized level for rising-edge detection.
  always_ff @(posedge mck) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= tick;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // One-cycle tick event, suppressed while the clock is held in restim.
  // The >= compares keep the counters in range even from a corrupted value.
  assign w_tev   = r_sync2 & ~r_sync3;
  assign w_count = w_tev & ~restim;
  assign w_sec   = w_count & (r_tim0 >= 8'd199);
  assign w_min   = w_sec & (r_tim1 >= 6'd59);

  // Cascaded 5 ms / second / minute counters; restim clears and holds them.
  always_ff @(posedge mck) begin
    if (rst || restim) begin
      r_tim0 <= '0;
      r_tim1 <= '0;
      r_timm <= '0;
    end else if (w_count) begin
      r_tim0 <= w_sec ? 8'd0 : r_tim0 + 8'd1;
      if (w_sec) begin
        r_tim1 <= w_min ? 6'd0 : r_tim1 + 6'd1;
      end
      if (w_min) begin
        r_timm <= r_timm + 21'd1;
      end
    end
  end

  // Event set vector and acknowledge clear vector for the status flags.
  assign w_set = {w_min, w_sec, w_count};
  assign w_clr = bus.tack_wr ? bus.wdat : 3'b000;

  // Sticky status flags: clear first, then set, so a simultaneous event wins.
  always_ff @(posedge mck) begin
    if (rst) begin
      r_tsta <= '0;
    end else begin
      r_tsta <= (r_tsta & ~w_clr) | w_set;
    end
  end

  // Interrupt mask register, loaded whole on a mask write.
  always_ff @(posedge mck) begin
    if (rst) begin
      r_tmk <= '0;
    end else if (bus.tmk_wr) begin
      r_tmk <= bus.wdat;
    end
  end

  // Registered interrupt request from the masked status flags.
  always_ff @(posedge mck) begin
    if (rst) begin
      r_tirq <= 1'b0;
    end else begin
      r_tirq <= |(r_tsta & r_tmk);
    end
  end

  assign tim0     = r_tim0;
  assign tim1     = r_tim1;
  assign timm     = r_timm;
  assign bus.tsta = r_tsta;
  assign bus.tmk  = r_tmk;
  assign bus.tirq = r_tirq;

endmodule
